// File: rtl/maze_pkg.sv
// Shared maze constants, direction encoding, player FSM states and cell indexing.
// Latency: none (declarations only).
// Backpressure: not applicable.
package maze_pkg;

    localparam int MAZE_DIM   = 16;
    localparam int MAZE_CELLS = 256;

    // Same direction encoding the carver uses for its random walk.
    localparam logic [1:0] DIR_UP    = 2'b00;
    localparam logic [1:0] DIR_LEFT  = 2'b01;
    localparam logic [1:0] DIR_DOWN  = 2'b10;
    localparam logic [1:0] DIR_RIGHT = 2'b11;

    typedef logic [1:0] state_t;
    localparam state_t IDLE = 2'd0;
    localparam state_t PLAY = 2'd1;
    localparam state_t WIN  = 2'd2;

    // Bitmap index of cell (x,y): x + 16*y.
    function automatic logic [7:0] idx(input logic [3:0] x, input logic [3:0] y);
        return {y, x};
    endfunction

endpackage

// File: rtl/maze_debounce.sv
// One button: 2-flop synchronizer, stability counter, rising-edge press pulse.
// Latency: press pulse 2+DEBOUNCE_CYCLES cycles after a stable raw rise.
// Backpressure: none; presses not consumed downstream are simply lost.
module maze_debounce #(
    parameter int DEBOUNCE_CYCLES = 500000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic btn_raw_i,
    output logic press_o
);

    logic        sync1_q;
    logic        sync2_q;
    logic        level_q;
    logic        level_prev_q;
    logic [19:0] cnt_q;

    // Synchronize, then accept a new level only after it has been stable long enough.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sync1_q      <= 1'b0;
            sync2_q      <= 1'b0;
            level_q      <= 1'b0;
            level_prev_q <= 1'b0;
            cnt_q        <= '0;
        end else begin
            sync1_q      <= btn_raw_i;
            sync2_q      <= sync1_q;
            level_prev_q <= level_q;
            if (sync2_q != level_q) begin
                if (cnt_q == 20'(DEBOUNCE_CYCLES - 1)) begin
                    level_q <= sync2_q;
                    cnt_q   <= '0;
                end else begin
                    cnt_q <= cnt_q + 20'd1;
                end
            end else begin
                cnt_q <= '0;
            end
        end
    end

    assign press_o = level_q & ~level_prev_q;

endmodule

// File: rtl/maze_player_ctrl.sv
// Player marker FSM: debounced button moves over the carved maze, bump on illegal move, win at finish.
// Latency: press pulse -> position/bump/move_count at the next edge; win one edge after reaching finish.
// Backpressure: none; simultaneous presses resolve by priority up>left>down>right, the rest are dropped.
module maze_player_ctrl
    import maze_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int MOVE_CNT_W      = 10
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [MAZE_CELLS-1:0] maze_data,
    input  logic                  carve_finish,
    input  logic [4:0]            maze_width,
    input  logic [4:0]            maze_height,
    input  logic [3:0]            finish_x,
    input  logic [3:0]            finish_y,
    input  logic                  btn_up,
    input  logic                  btn_left,
    input  logic                  btn_down,
    input  logic                  btn_right,
    output logic [3:0]            player_x,
    output logic [3:0]            player_y,
    output logic                  playing,
    output logic                  won,
    output logic                  bump,
    output logic [MOVE_CNT_W-1:0] move_count
);

    logic press_up, press_left, press_down, press_right;

    maze_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_up (
        .clk(clk), .rst_n(rst_n), .btn_raw_i(btn_up), .press_o(press_up));
    maze_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_left (
        .clk(clk), .rst_n(rst_n), .btn_raw_i(btn_left), .press_o(press_left));
    maze_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_down (
        .clk(clk), .rst_n(rst_n), .btn_raw_i(btn_down), .press_o(press_down));
    maze_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_right (
        .clk(clk), .rst_n(rst_n), .btn_raw_i(btn_right), .press_o(press_right));

    state_t                state_q, state_d;
    logic [3:0]            px_q, px_d, py_q, py_d;
    logic [MOVE_CNT_W-1:0] mc_q, mc_d;
    logic                  bump_q, bump_d;
    logic                  playing_q, won_q;
    logic                  cf_q, cf_prev_q;

    // The carve_finish history resets high so a flag already high at reset release
    // is not mistaken for a rise; a low flag just yields a harmless fall in IDLE.
    logic cf_rise, cf_fall;
    assign cf_rise = cf_q & ~cf_prev_q;
    assign cf_fall = ~cf_q & cf_prev_q;

    logic       any_press;
    logic [1:0] dir;
    logic [3:0] tx, ty;
    logic       in_bounds;
    logic       move_ok;
    logic [4:0] x5, y5;

    assign any_press = press_up | press_left | press_down | press_right;
    assign x5        = {1'b0, px_q};
    assign y5        = {1'b0, py_q};

    // Pick the winning direction and check bounds (5-bit, no wrap) and the target cell.
    always_comb begin
        dir       = press_up   ? DIR_UP   :
                    press_left ? DIR_LEFT :
                    press_down ? DIR_DOWN : DIR_RIGHT;
        tx        = px_q;
        ty        = py_q;
        in_bounds = 1'b0;
        case (dir)
            DIR_UP: begin
                in_bounds = (py_q != 4'd0);
                ty        = py_q - 4'd1;
            end
            DIR_LEFT: begin
                in_bounds = (px_q != 4'd0);
                tx        = px_q - 4'd1;
            end
            DIR_DOWN: begin
                in_bounds = ((y5 + 5'd1) < maze_height);
                ty        = py_q + 4'd1;
            end
            default: begin
                in_bounds = ((x5 + 5'd1) < maze_width);
                tx        = px_q + 4'd1;
            end
        endcase
        move_ok = in_bounds && maze_data[idx(tx, ty)];
    end

    // Game FSM; a carve_finish fall overrides everything, including a same-cycle move.
    always_comb begin
        state_d = state_q;
        px_d    = px_q;
        py_d    = py_q;
        mc_d    = mc_q;
        bump_d  = 1'b0;
        if (cf_fall) begin
            state_d = IDLE;
            px_d    = 4'd0;
            py_d    = 4'd0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (cf_rise) begin
                        state_d = PLAY;
                        px_d    = 4'd0;
                        py_d    = 4'd0;
                        mc_d    = '0;
                    end
                end
                PLAY: begin
                    if (px_q == finish_x && py_q == finish_y) begin
                        state_d = WIN;
                    end else if (any_press) begin
                        if (move_ok) begin
                            px_d = tx;
                            py_d = ty;
                            if (!(&mc_q)) begin
                                mc_d = mc_q + MOVE_CNT_W'(1);
                            end
                        end else begin
                            bump_d = 1'b1;
                        end
                    end
                end
                WIN: begin
                    state_d = WIN;
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end
    end

    // State, position and registered status outputs.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            px_q      <= 4'd0;
            py_q      <= 4'd0;
            mc_q      <= '0;
            bump_q    <= 1'b0;
            playing_q <= 1'b0;
            won_q     <= 1'b0;
            cf_q      <= 1'b1;
            cf_prev_q <= 1'b1;
        end else begin
            state_q   <= state_d;
            px_q      <= px_d;
            py_q      <= py_d;
            mc_q      <= mc_d;
            bump_q    <= bump_d;
            playing_q <= (state_d == PLAY);
            won_q     <= (state_d == WIN);
            cf_q      <= carve_finish;
            cf_prev_q <= cf_q;
        end
    end

    assign player_x   = px_q;
    assign player_y   = py_q;
    assign playing    = playing_q;
    assign won        = won_q;
    assign bump       = bump_q;
    assign move_count = mc_q;

endmodule

// File: tb/tb_maze_player_ctrl.sv
module tb_maze_player_ctrl;
    import maze_pkg::*;

    localparam int D = 4;

    logic         clk = 1'b0;
    logic         rst_n;
    logic [255:0] maze_data;
    logic         carve_finish;
    logic [4:0]   maze_width, maze_height;
    logic [3:0]   finish_x, finish_y;
    logic         btn_up, btn_left, btn_down, btn_right;
    logic [3:0]   player_x, player_y;
    logic         playing, won, bump;
    logic [9:0]   move_count;

    maze_player_ctrl #(.DEBOUNCE_CYCLES(D), .MOVE_CNT_W(10)) dut (
        .clk(clk), .rst_n(rst_n), .maze_data(maze_data), .carve_finish(carve_finish),
        .maze_width(maze_width), .maze_height(maze_height),
        .finish_x(finish_x), .finish_y(finish_y),
        .btn_up(btn_up), .btn_left(btn_left), .btn_down(btn_down), .btn_right(btn_right),
        .player_x(player_x), .player_y(player_y), .playing(playing), .won(won),
        .bump(bump), .move_count(move_count));

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int         cyc;
        logic [3:0] x;
        logic [3:0] y;
        logic       pl;
        logic       wn;
        logic       bp;
        logic [9:0] mc;
    } exp_t;

    exp_t q[$];
    int   n_chk  = 0;
    int   n_fail = 0;

    logic [20:0] cur, prev;
    logic        mon_en = 1'b0;
    assign cur = {player_x, player_y, playing, won, bump, move_count};

    // Bench-side model of where the player should be.
    logic [3:0] ex = 4'd0, ey = 4'd0;
    logic [9:0] emc = 10'd0;

    task automatic expect_at(input int c, input logic [3:0] x, input logic [3:0] y,
                             input logic pl, input logic wn, input logic bp, input logic [9:0] mc);
        exp_t e;
        e.cyc = c; e.x = x; e.y = y; e.pl = pl; e.wn = wn; e.bp = bp; e.mc = mc;
        q.push_back(e);
    endtask

    // Monitor: every change of the output tuple must match the next queued expectation, cycle included.
    initial begin
        forever begin
            @(negedge clk);
            if (mon_en && cur !== prev) begin
                n_chk++;
                if (q.size() == 0) begin
                    n_fail++;
                    $display("FAIL unexpected_change cyc=%0d got x=%0d y=%0d pl=%b won=%b bump=%b mc=%0d, required no change",
                             cyc, player_x, player_y, playing, won, bump, move_count);
                end else begin
                    exp_t e;
                    e = q.pop_front();
                    if (cur !== {e.x, e.y, e.pl, e.wn, e.bp, e.mc} || cyc != e.cyc) begin
                        n_fail++;
                        $display("FAIL event cyc=%0d got x=%0d y=%0d pl=%b won=%b bump=%b mc=%0d, required cyc=%0d x=%0d y=%0d pl=%b won=%b bump=%b mc=%0d",
                                 cyc, player_x, player_y, playing, won, bump, move_count,
                                 e.cyc, e.x, e.y, e.pl, e.wn, e.bp, e.mc);
                    end
                end
                prev = cur;
            end
        end
    end

    // kind: 0 no response, 1 legal move to (nx,ny), 2 bump, 3 legal move then win.
    task automatic press(input logic [3:0] m, input int kind, input logic [3:0] nx, input logic [3:0] ny);
        int c;
        @(posedge clk); #1;
        c = cyc;
        {btn_up, btn_left, btn_down, btn_right} = m;
        case (kind)
            1: begin
                ex = nx; ey = ny; emc = emc + 10'd1;
                expect_at(c + 3 + D, ex, ey, 1'b1, 1'b0, 1'b0, emc);
            end
            2: begin
                expect_at(c + 3 + D, ex, ey, 1'b1, 1'b0, 1'b1, emc);
                expect_at(c + 4 + D, ex, ey, 1'b1, 1'b0, 1'b0, emc);
            end
            3: begin
                ex = nx; ey = ny; emc = emc + 10'd1;
                expect_at(c + 3 + D, ex, ey, 1'b1, 1'b0, 1'b0, emc);
                expect_at(c + 4 + D, ex, ey, 1'b0, 1'b1, 1'b0, emc);
            end
            default: ;
        endcase
        repeat (D + 6) @(posedge clk);
        #1 {btn_up, btn_left, btn_down, btn_right} = 4'b0000;
        repeat (D + 8) @(posedge clk);
    endtask

    task automatic cf_rise(input logic wins);
        int c;
        @(posedge clk); #1;
        c = cyc;
        carve_finish = 1'b1;
        ex = 4'd0; ey = 4'd0; emc = 10'd0;
        expect_at(c + 2, 4'd0, 4'd0, 1'b1, 1'b0, 1'b0, 10'd0);
        if (wins) expect_at(c + 3, 4'd0, 4'd0, 1'b0, 1'b1, 1'b0, 10'd0);
        repeat (6) @(posedge clk);
    endtask

    task automatic cf_fall(input logic active);
        int c;
        @(posedge clk); #1;
        c = cyc;
        carve_finish = 1'b0;
        if (active) expect_at(c + 2, 4'd0, 4'd0, 1'b0, 1'b0, 1'b0, emc);
        ex = 4'd0; ey = 4'd0;
        repeat (6) @(posedge clk);
    endtask

    task automatic check_now(input string name, input logic [20:0] req);
        @(negedge clk);
        n_chk++;
        if (cur !== req) begin
            n_fail++;
            $display("FAIL %s got %h required %h", name, cur, req);
        end
    endtask

    initial begin
        int c;
        rst_n = 1'b0; carve_finish = 1'b1;
        maze_data = '0; maze_width = 5'd4; maze_height = 5'd4;
        finish_x = 4'd1; finish_y = 4'd1;
        {btn_up, btn_left, btn_down, btn_right} = 4'b0000;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        check_now("reset_state", 21'd0);
        prev   = cur;
        mon_en = 1'b1;

        // carve_finish high through reset release: no game, presses ignored.
        maze_data[0] = 1'b1; maze_data[1] = 1'b1; maze_data[17] = 1'b1;
        repeat (5) @(posedge clk);
        press(4'b0001, 0, 4'd0, 4'd0);
        press(4'b0010, 0, 4'd0, 4'd0);
        check_now("idle_no_start", 21'd0);

        // Maze 1: 4x4, path (0,0),(1,0),(1,1), finish (1,1).
        cf_fall(1'b0);
        cf_rise(1'b0);
        press(4'b1000, 2, 4'd0, 4'd0);   // up: y=0
        press(4'b0100, 2, 4'd0, 4'd0);   // left: x=0
        press(4'b0010, 2, 4'd0, 4'd0);   // down: wall at (0,1)
        press(4'b0001, 1, 4'd1, 4'd0);   // right
        press(4'b0010, 3, 4'd1, 4'd1);   // down onto finish
        press(4'b0100, 0, 4'd0, 4'd0);   // ignored in WIN
        cf_fall(1'b1);

        // Maze 2: width 3, row 0 cells 0..3 carved, row 1 cells 0..2 carved.
        maze_data = '0;
        for (int i = 0; i < 4; i++) maze_data[i] = 1'b1;
        for (int i = 16; i < 19; i++) maze_data[i] = 1'b1;
        maze_width = 5'd3; maze_height = 5'd4; finish_x = 4'd0; finish_y = 4'd3;
        cf_rise(1'b0);
        press(4'b0100, 2, 4'd0, 4'd0);   // left at x=0, no wrap
        press(4'b0001, 1, 4'd1, 4'd0);
        press(4'b0001, 1, 4'd2, 4'd0);
        press(4'b0001, 2, 4'd0, 4'd0);   // x=3 carved but outside width

        // Glitch shorter than the debounce window.
        @(posedge clk); #1 btn_up = 1'b1;
        repeat (3) @(posedge clk);
        #1 btn_up = 1'b0;
        repeat (15) @(posedge clk);

        press(4'b0010, 1, 4'd2, 4'd1);   // down
        press(4'b1001, 1, 4'd2, 4'd0);   // up+right together: up wins
        press(4'b0100, 1, 4'd1, 4'd0);   // left

        // Fall in the same cycle as a legal down press from (1,0).
        @(posedge clk); #1;
        c = cyc;
        btn_down = 1'b1;
        repeat (5) @(posedge clk);
        #1 carve_finish = 1'b0;
        expect_at(c + 3 + D, 4'd0, 4'd0, 1'b0, 1'b0, 1'b0, emc);
        ex = 4'd0; ey = 4'd0;
        repeat (6) @(posedge clk);
        #1 btn_down = 1'b0;
        repeat (D + 8) @(posedge clk);
        cf_rise(1'b0);                    // restart, move_count back to 0

        // Maze 3: 1x1 with finish (0,0) wins right after start.
        cf_fall(1'b1);
        maze_data = '0; maze_data[0] = 1'b1;
        maze_width = 5'd1; maze_height = 5'd1; finish_x = 4'd0; finish_y = 4'd0;
        cf_rise(1'b1);
        repeat (10) @(posedge clk);
        @(negedge clk);

        n_chk++;
        if (q.size() != 0) begin
            n_fail++;
            $display("FAIL pending_events got %0d outstanding required 0", q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
